// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared FSK/Hamming link constants and transmit FSM states
// Contents:
//   FRAME_WIDTH  data bits per serial frame
//   BIT_CLKS     clocks per serial bit; the receiver uses the same value
//   GAP_CLKS     minimum idle clocks between consecutive frames
//   tx_state_t   serializer FSM states
package link_pkg;

    localparam int FRAME_WIDTH = 11;
    localparam int BIT_CLKS    = 16;
    localparam int GAP_CLKS    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/encode_processor_if.sv
// rtl/encode_processor_if.sv - load handshake and serial output bundle of the encode processor
// Signals:
//   dataseq  word to transmit, sampled when load & ready
//   load     request to accept dataseq
//   ready    serializer can accept a word this cycle
//   txbit    serial data out, LSB first
//   sending  high for the whole frame
//   done     one-cycle pulse after the last bit period
//   busy     frame in progress or word buffered
// Modports: master = word source and serial consumer, slave = encode_processor.
interface encode_processor_if #(
    parameter int WIDTH = link_pkg::FRAME_WIDTH
) ();

    logic [WIDTH-1:0] dataseq;
    logic             load;
    logic             ready;
    logic             txbit;
    logic             sending;
    logic             done;
    logic             busy;

    modport master (
        output dataseq, load,
        input  ready, txbit, sending, done, busy
    );

    modport slave (
        input  dataseq, load,
        output ready, txbit, sending, done, busy
    );

endinterface

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - modulo-PERIOD counter marking the last clock of each serial bit
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   clear     hold the counter at zero (used outside the shift phase)
//   bit_tick  high in the last cycle of each bit period
module bit_timer #(
    parameter int PERIOD = link_pkg::BIT_CLKS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] cnt;

    // PERIOD is a power of two, so the counter wraps to zero on its own
    // at every bit boundary.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = !clear && (cnt == CW'(PERIOD - 1));

endmodule

// File: rtl/encode_processor.sv
// rtl/encode_processor.sv - transmit-side serializer: 11-bit word out LSB-first, framed by sending
// Ports:
//   clk    system clock, all logic on rising edge
//   reset  synchronous active-high reset
//   bus    encode_processor_if.slave: dataseq/load/ready handshake in,
//          txbit/sending/done/busy out
module encode_processor #(
    parameter int WIDTH    = link_pkg::FRAME_WIDTH,
    parameter int BIT_CLKS = link_pkg::BIT_CLKS,
    parameter int GAP_CLKS = link_pkg::GAP_CLKS
) (
    input  logic                clk,
    input  logic                reset,
    encode_processor_if.slave   bus
);

    import link_pkg::*;

    localparam int IW = $clog2(WIDTH);
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    tx_state_t        state, state_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic [WIDTH-1:0] hold_data, hold_data_n;
    logic             hold_valid, hold_valid_n;
    logic [IW-1:0]    bit_idx, bit_idx_n;
    logic [GW-1:0]    gap_cnt, gap_cnt_n;
    logic             done_q, done_n;
    logic             bit_tick;
    logic             accept;

    assign accept = bus.load && !hold_valid;

    // The timer only runs while shifting, so it is at zero on the first
    // cycle of every frame.
    bit_timer #(
        .PERIOD (BIT_CLKS)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state != SHIFT),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_q    <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            shift_q    <= shift_n;
            hold_data  <= hold_data_n;
            hold_valid <= hold_valid_n;
            bit_idx    <= bit_idx_n;
            gap_cnt    <= gap_cnt_n;
            done_q     <= done_n;
        end
    end

    always_comb begin
        state_n      = state;
        shift_n      = shift_q;
        hold_data_n  = hold_data;
        hold_valid_n = hold_valid;
        bit_idx_n    = bit_idx;
        gap_cnt_n    = gap_cnt;
        done_n       = 1'b0;

        case (state)
            IDLE: begin
                if (hold_valid) begin
                    shift_n      = hold_data;
                    hold_valid_n = 1'b0;
                    bit_idx_n    = '0;
                    state_n      = SHIFT;
                end else if (accept) begin
                    // Direct path: an idle serializer bypasses the buffer.
                    shift_n   = bus.dataseq;
                    bit_idx_n = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    shift_n = shift_q >> 1;
                    if (bit_idx == IW'(WIDTH - 1)) begin
                        done_n    = 1'b1;
                        gap_cnt_n = '0;
                        state_n   = GAP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CLKS - 1)) begin
                    if (hold_valid) begin
                        shift_n      = hold_data;
                        hold_valid_n = 1'b0;
                        bit_idx_n    = '0;
                        state_n      = SHIFT;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Words accepted while a frame is active wait in the buffer; this
        // overrides a same-cycle buffer-to-shifter transfer so the new word
        // is kept.
        if (accept && (state != IDLE)) begin
            hold_data_n  = bus.dataseq;
            hold_valid_n = 1'b1;
        end
    end

    assign bus.ready   = !hold_valid;
    assign bus.sending = (state == SHIFT);
    assign bus.txbit   = (state == SHIFT) && shift_q[0];
    assign bus.done    = done_q;
    assign bus.busy    = (state != IDLE) || hold_valid;

endmodule

// File: tb/tb_encode_processor.sv
// tb/tb_encode_processor.sv - directed self-checking bench for encode_processor
module tb_encode_processor;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    encode_processor_if #(.WIDTH(11)) bus ();

    encode_processor #(
        .WIDTH    (11),
        .BIT_CLKS (16),
        .GAP_CLKS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model: frame starts on the sending rise, each bit is
    // sampled 8 clocks into its 16-clock period.
    logic [10:0] rx_word;
    logic [10:0] rx_last;
    int          rx_frames;
    int          rx_cnt;
    logic        rx_active;
    logic        rx_prev;

    initial begin
        rx_word   = '0;
        rx_last   = '0;
        rx_frames = 0;
        rx_cnt    = 0;
        rx_active = 1'b0;
        rx_prev   = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.sending && !rx_prev) begin
            rx_cnt    = 0;
            rx_active = 1'b1;
        end else if (rx_active) begin
            rx_cnt = rx_cnt + 1;
        end
        if (rx_active && bus.sending && (rx_cnt % 16 == 8) && (rx_cnt / 16 < 11)) begin
            rx_word[rx_cnt / 16] = bus.txbit;
        end
        if (rx_active && !bus.sending) begin
            rx_last   = rx_word;
            rx_frames = rx_frames + 1;
            rx_active = 1'b0;
        end
        rx_prev = bus.sending;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the cycle before the load edge; returns in the first
    // sending cycle of the new frame.
    task automatic start(input logic [10:0] word);
        bus.dataseq = word;
        bus.load    = 1'b1;
        tick();
        bus.load    = 1'b0;
    endtask

    // Called in the first sending cycle; returns in the done cycle.
    // Optional loads are driven at frame cycles ld_cyc / ld3_cyc (-1 = none).
    task automatic run_frame(input logic [10:0] word, input int ld_cyc, input logic [10:0] ld_word,
                             input int ld3_cyc, input logic [10:0] ld3_word, input string tag);
        logic [15:0] obs_t, obs_s, obs_r, exp_r;
        logic        seen_done;
        seen_done = 1'b0;
        for (int k = 0; k < 11; k++) begin
            obs_t = '0;
            obs_s = '0;
            obs_r = '0;
            exp_r = '0;
            for (int j = 0; j < 16; j++) begin
                int i;
                i = k * 16 + j;
                obs_t[j]  = bus.txbit;
                obs_s[j]  = bus.sending;
                obs_r[j]  = bus.ready;
                exp_r[j]  = (ld_cyc < 0) || (i <= ld_cyc);
                seen_done = seen_done | bus.done;
                bus.load  = (i == ld_cyc) || (i == ld3_cyc);
                bus.dataseq = (i == ld_cyc) ? ld_word :
                              ((i == ld3_cyc) ? ld3_word : 11'($urandom));
                tick();
            end
            check($sformatf("%s sending b%0d", tag, k), {16'h0, obs_s}, 32'h0000_FFFF);
            check($sformatf("%s txbit b%0d", tag, k), {16'h0, obs_t}, word[k] ? 32'h0000_FFFF : 32'h0);
            check($sformatf("%s ready b%0d", tag, k), {16'h0, obs_r}, {16'h0, exp_r});
        end
        bus.load = 1'b0;
        check({tag, " done inside frame"}, {31'h0, seen_done}, 32'h0);
    endtask

    logic [10:0] lb_words [3];
    int          frames_before;
    logic        seen_s, seen_d;

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.dataseq = '0;
        lb_words[0] = 11'h001;
        lb_words[1] = 11'h400;
        lb_words[2] = 11'h2AA;

        tick();
        tick();
        check("reset ready",   {31'h0, bus.ready},   32'h1);
        check("reset txbit",   {31'h0, bus.txbit},   32'h0);
        check("reset sending", {31'h0, bus.sending}, 32'h0);
        check("reset done",    {31'h0, bus.done},    32'h0);
        check("reset busy",    {31'h0, bus.busy},    32'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Single frame 11'h5A3: bits LSB-first 1,1,0,0,0,1,0,1,1,0,1
        frames_before = rx_frames;
        start(11'h5A3);
        check("f1 first cycle busy", {31'h0, bus.busy}, 32'h1);
        run_frame(11'h5A3, -1, 11'h0, -1, 11'h0, "f1");
        check("f1 done",        {31'h0, bus.done},    32'h1);
        check("f1 end sending", {31'h0, bus.sending}, 32'h0);
        check("f1 end txbit",   {31'h0, bus.txbit},   32'h0);
        check("f1 end ready",   {31'h0, bus.ready},   32'h1);
        tick();
        check("f1 done pulse width", {31'h0, bus.done}, 32'h0);
        check("f1 gap busy",         {31'h0, bus.busy}, 32'h1);
        check("f1 rx word",   {21'h0, rx_last}, 32'h5A3);
        check("f1 rx frames", rx_frames, frames_before + 1);
        tick();
        check("f1 idle busy", {31'h0, bus.busy}, 32'h0);
        for (int i = 0; i < 5; i++) tick();

        // Back-to-back 7FF then 000, third load ignored while buffer full
        start(11'h7FF);
        run_frame(11'h7FF, 9, 11'h000, 30, 11'h555, "f2a");
        check("f2a done",        {31'h0, bus.done},    32'h1);
        check("f2a end sending", {31'h0, bus.sending}, 32'h0);
        check("f2a end ready",   {31'h0, bus.ready},   32'h0);
        tick();
        check("f2a gap2 sending", {31'h0, bus.sending}, 32'h0);
        check("f2a gap2 done",    {31'h0, bus.done},    32'h0);
        tick();
        check("f2b start sending", {31'h0, bus.sending}, 32'h1);
        check("f2b start ready",   {31'h0, bus.ready},   32'h1);
        run_frame(11'h000, -1, 11'h0, -1, 11'h0, "f2b");
        check("f2b done", {31'h0, bus.done}, 32'h1);
        tick();
        check("f2b post-done busy", {31'h0, bus.busy}, 32'h1);
        tick();
        check("f2b busy drop", {31'h0, bus.busy}, 32'h0);
        seen_s = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen_s = seen_s | bus.sending;
            tick();
        end
        check("no third frame", {31'h0, seen_s}, 32'h0);

        // Reset at frame cycle 40 with a buffered word
        start(11'h123);
        for (int i = 0; i < 40; i++) begin
            bus.load    = (i == 5);
            bus.dataseq = (i == 5) ? 11'h3C3 : 11'($urandom);
            tick();
        end
        bus.load = 1'b0;
        check("pre-reset ready",   {31'h0, bus.ready},   32'h0);
        check("pre-reset sending", {31'h0, bus.sending}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset sending", {31'h0, bus.sending}, 32'h0);
        check("mid reset txbit",   {31'h0, bus.txbit},   32'h0);
        check("mid reset ready",   {31'h0, bus.ready},   32'h1);
        check("mid reset busy",    {31'h0, bus.busy},    32'h0);
        check("mid reset done",    {31'h0, bus.done},    32'h0);
        seen_s = 1'b0;
        seen_d = 1'b0;
        for (int i = 0; i < 200; i++) begin
            seen_s = seen_s | bus.sending;
            seen_d = seen_d | bus.done;
            tick();
        end
        check("post reset no frame", {31'h0, seen_s}, 32'h0);
        check("post reset no done",  {31'h0, seen_d}, 32'h0);

        // Reset together with load: word must not be accepted
        reset       = 1'b1;
        bus.load    = 1'b1;
        bus.dataseq = 11'h7FF;
        tick();
        reset    = 1'b0;
        bus.load = 1'b0;
        check("reset+load busy",    {31'h0, bus.busy},    32'h0);
        check("reset+load sending", {31'h0, bus.sending}, 32'h0);
        tick();
        check("reset+load stays idle", {31'h0, bus.busy}, 32'h0);

        // Loopback through the receiver model
        for (int w = 0; w < 3; w++) begin
            frames_before = rx_frames;
            start(lb_words[w]);
            run_frame(lb_words[w], -1, 11'h0, -1, 11'h0, $sformatf("lb%0d", w));
            check($sformatf("lb%0d done", w), {31'h0, bus.done}, 32'h1);
            tick();
            check($sformatf("lb%0d rx word", w), {21'h0, rx_last}, {21'h0, lb_words[w]});
            check($sformatf("lb%0d rx refresh", w), rx_frames, frames_before + 1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
